// File: rtl/svnet_fifo_burst_reader.sv
// svnet_fifo_burst_reader: pops fixed-length bursts from a show-ahead FIFO, with flush-driven short bursts
module svnet_fifo_burst_reader #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter int BURST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [$clog2(DEPTH):0] fifo_used_space,
  input  logic [WIDTH-1:0]       fifo_read_data,
  output logic                   fifo_read,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_first,
  output logic                   out_last,
  output logic [15:0]            burst_count
);
  localparam int UW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(BURST) + 1;
  localparam logic [UW-1:0] BURST_U = UW'(BURST);
  localparam logic [RW-1:0] BURST_R = RW'(BURST);
  localparam logic [RW-1:0] ONE_R = RW'(1);
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t            state_q;
  logic [RW-1:0]     rem_q, len_q, len_d;
  logic              flush_pending_q, out_valid_q, out_first_q, out_last_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [15:0]       burst_count_q;
  logic              start_full, start_flush, pend_clr;
  // burst start decisions and the pop strobe; a flush only drains what is below a full burst
  always_comb begin
    start_full  = state_q == S_IDLE && fifo_used_space >= BURST_U;
    pend_clr    = state_q == S_IDLE && !start_full && flush_pending_q;
    start_flush = pend_clr && fifo_used_space != '0;
    len_d       = start_full ? BURST_R : fifo_used_space[RW-1:0];
    fifo_read   = state_q == S_BURST && rem_q != '0 && (!out_valid_q || out_ready);
  end
  // control FSM, output register and completed-burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rem_q           <= '0;
      len_q           <= '0;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_first_q     <= 1'b0;
      out_last_q      <= 1'b0;
      burst_count_q   <= '0;
    end else begin
      flush_pending_q <= flush || (flush_pending_q && !pend_clr);
      if (start_full || start_flush) begin
        state_q <= S_BURST;
        rem_q   <= len_d;
        len_q   <= len_d;
      end else if (fifo_read) begin
        rem_q <= rem_q - ONE_R;
        if (rem_q == ONE_R) state_q <= S_IDLE;
      end
      if (fifo_read) begin
        out_valid_q <= 1'b1;
        out_data_q  <= fifo_read_data;
        out_first_q <= rem_q == len_q;
        out_last_q  <= rem_q == ONE_R;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && out_ready && out_last_q) burst_count_q <= burst_count_q + 16'd1;
    end
  end
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_first   = out_first_q;
  assign out_last    = out_last_q;
  assign burst_count = burst_count_q;
  a_read_nonempty: assert property (@(posedge clk) disable iff (rst) fifo_read |-> fifo_used_space != '0);
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid_q && !out_ready |=> out_valid_q && $stable(out_data_q) && $stable(out_first_q) && $stable(out_last_q));
endmodule

// File: doc/svnet_fifo_burst_reader.md
SVNET_FIFO_BURST_READER -- requirements
Module: svnet_fifo_burst_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: data word width in bits, matching the upstream RAM FIFO.
REQ-002 The block SHALL have parameter DEPTH, default 1: upstream RAM FIFO depth, which sizes fifo_used_space.
REQ-003 The block SHALL have parameter BURST, default 1: full burst length in words, legal range 1 <= BURST <= DEPTH.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port fifo_used_space, input, $clog2(DEPTH)+1 bits: upstream FIFO occupancy.
REQ-008 The block SHALL have port fifo_read_data, input, WIDTH bits: upstream FIFO head word (show-ahead), valid whenever fifo_used_space > 0.
REQ-009 The block SHALL have port fifo_read, output, 1 bit: pops the upstream FIFO head this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit: one-cycle request to drain a partial remainder.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data, out_first and out_last are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream sink accepts the beat.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: burst data word.
REQ-014 The block SHALL have port out_first, output, 1 bit: marks the first beat of a burst.
REQ-015 The block SHALL have port out_last, output, 1 bit: marks the last beat of a burst.
REQ-016 The block SHALL have port burst_count, output, 16 bits: number of completed bursts, wrapping modulo 2^16.

Function
REQ-017 The state machine SHALL have exactly two states, IDLE and BURST, with a down-counter rem of width $clog2(BURST)+1.
REQ-018 In IDLE, if fifo_used_space >= BURST, the block SHALL go to BURST with rem = BURST.
REQ-019 Otherwise, in IDLE, if flush_pending = 1 and fifo_used_space > 0, the block SHALL go to BURST with rem = fifo_used_space and clear flush_pending.
REQ-020 In IDLE with flush_pending = 1 and fifo_used_space = 0, the block SHALL clear flush_pending and stay in IDLE.
REQ-021 A flush pulse SHALL set flush_pending sticky; a flush arriving in the same cycle as a clear SHALL win (flush_pending stays 1).
REQ-022 flush_pending SHALL survive full bursts, so a drain of N words yields floor(N/BURST) full bursts followed by one short burst of N mod BURST words, if nonzero.
REQ-023 fifo_read SHALL be asserted exactly when state = BURST and rem > 0 and (out_valid = 0 or out_ready = 1); it SHALL be 0 in IDLE.
REQ-024 On each fifo_read, the output register SHALL load fifo_read_data into out_data and set out_valid = 1 on the next edge (latency 1 cycle), and rem SHALL decrement.
REQ-025 out_first SHALL be 1 on the beat loaded when rem equals the initial burst length; out_last SHALL be 1 on the beat loaded when rem = 1; both SHALL be 1 for a 1-word burst.
REQ-026 When out_valid = 1 and out_ready = 1 with no new load, out_valid SHALL fall on the next edge.
REQ-027 While out_valid = 1 and out_ready = 0, out_data, out_first and out_last SHALL be held stable.
REQ-028 The block SHALL return to IDLE on the edge following the fifo_read of the last word; the IDLE decision then uses the updated fifo_used_space, giving at least one idle cycle between bursts.
REQ-029 burst_count SHALL increment by 1 when a beat with out_last = 1 is accepted (out_valid and out_ready both 1).
REQ-030 Assertions SHALL flag fifo_read while fifo_used_space = 0, and any change of the output fields while out_valid = 1 and out_ready = 0.

Reset
REQ-031 While rst = 1, and immediately on its assertion independent of clk, the block SHALL force: state = IDLE, rem = 0, flush_pending = 0, out_valid = 0, out_data = 0, out_first = 0, out_last = 0, burst_count = 0, fifo_read = 0.
REQ-032 Assertion of rst mid-burst SHALL drop the in-flight beat and the partial burst without a completion count; the upstream FIFO is reset by the same system reset.

Verification (WIDTH=8, DEPTH=16, BURST=4)
REQ-033 Preload 0x10..0x13 with out_ready=1 -> the bench SHALL see four beats 0x10..0x13, out_first on 0x10, out_last on 0x13, burst_count=1.
REQ-034 Preload 3 words with no flush -> the bench SHALL see fifo_read=0 for 20 cycles; then a flush pulse -> a 3-beat burst with out_first on beat 1, out_last on beat 3, burst_count=1.
REQ-035 Hold out_ready=0 for 5 cycles after beat 2 -> out_data SHALL hold beat 2, fifo_read SHALL be 0, and all 4 words SHALL be delivered in order with no loss.
REQ-036 Preload 9 words, then flush -> the bench SHALL see bursts of 4, 4 and 1 beats (the last with out_first=out_last=1), burst_count=3, and flush_pending=0 at the end.
REQ-037 Assert rst after 2 beats of a burst -> out_valid SHALL go 0 before the next clk edge, burst_count=0 and state=IDLE.
REQ-038 Flush with an empty FIFO -> the bench SHALL see no fifo_read, flush_pending cleared the next cycle, and burst_count unchanged.
